shift_add_multiplier_datapath: RTL and testbench
================================================

Name: shift_add_multiplier_datapath

Overview:
- Sequential shift-and-add multiplier datapath; sits directly downstream of the multiplier Moore controller and consumes its load/shift/enable/sync_reset strobes.
- Returns the combinational `flag` that ends the controller's SHIFT state.
- Captures operands, performs one partial-product step per shift cycle, and presents a registered 2*WIDTH-bit product plus a one-cycle done pulse.
- Unsigned by default; optional signed mode uses magnitude/sign correction.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands and product.
- CNT_W, $clog2(WIDTH), step-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- load  input  1  capture operands (from controller).
- shift  input  1  perform one multiply step (from controller).
- sync_reset  input  1  active-low synchronous clear of working registers (from controller).
- enable  input  1  arm the step counter; qualifies load.
- multiplicand  input  WIDTH  operand A.
- multiplier  input  WIDTH  operand B.
- flag  output  1  combinational; high during the final step cycle.
- product  output  2*WIDTH  registered result.
- done  output  1  registered one-cycle pulse when product updates.

Behaviour:
- Clock and reset: one clock, `clk`; `reset` is synchronous and active-high.
- On reset: product=0, done=0, flag=0, and all working registers cleared (mcand, mplier, acc, count, armed, neg).
- Priority per edge: reset > sync_reset==0 > load&&enable > shift.
- Working registers:
  - mcand: 2*WIDTH, shifts left.
  - mplier: WIDTH, shifts right.
  - acc: 2*WIDTH accumulator.
  - count: CNT_W bits.
  - armed: 1 bit.
  - neg: 1 bit.
- Load (load && enable):
  - mcand = zero-extended |A|, mplier = |B|, acc=0, count=0, armed=1.
  - neg = A[MSB]^B[MSB] when SIGNED=1, else 0.
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1) and fits WIDTH bits unsigned.
  - load without enable is ignored.
  - load && enable while armed restarts the operation; the old partial result is discarded and product is held.
- Step (shift && armed):
  - acc += mplier[0] ? mcand : 0.
  - mcand <<= 1; mplier >>= 1; count += 1.
  - shift while not armed: no change.
- flag = armed && (count == WIDTH-1), combinational.
  - It is high during the WIDTH-th shift cycle, so the controller leaves SHIFT on the same edge the last step completes.
  - Exactly WIDTH shift cycles per operation.
- Completion edge (shift && flag):
  - product <= neg ? -(acc + partial) : (acc + partial), mod 2^(2*WIDTH).
  - done <= 1 for exactly one cycle; armed <= 0; count <= 0.
- Product hold: product holds until the next completion or reset. It is unaffected by sync_reset, so the controller's FINISH/SYNC_RESET ready window reads a stable value.
- sync_reset==0 (controller IDLE/SYNC_RESET):
  - Clears acc, mcand, mplier, count, armed and neg; product is kept.
  - Overrides a simultaneous shift or load.
- Arithmetic: no overflow possible (the |A|*|B| maximum fits 2*WIDTH bits). Signed result is exact for all operand pairs, including -2^(WIDTH-1) * -2^(WIDTH-1) = 2^(2*WIDTH-2).
- Latency: first shift edge after load edge → product valid after WIDTH shift edges; done coincides with the product update.
- Reset mid-operation: everything clears immediately, including product; no done pulse.

Test Plan:
- WIDTH=8, SIGNED=0, A=13, B=11:
  - Stimulus: load+enable 1 cycle, then shift 8 cycles.
  - Required: flag high only in shift cycle 8; product=143 and done=1 after edge 8; done=0 next cycle.
- WIDTH=8, SIGNED=0, A=255, B=255 → product=65025 (16'hFE01). A=0, B=200 → product=0 with a done pulse.
- WIDTH=8, SIGNED=1:
  - A=-3, B=5 → product=16'hFFF1.
  - A=-128, B=-128 → product=16'h4000.
  - A=127, B=-128 → product=16'hC080.
- After a completed 13*11, drive sync_reset=0 for 1 cycle mid-next-operation (after 3 shifts):
  - count/armed clear, flag stays 0, further shifts are ignored, product stays 143.
- Assert reset after 4 of 8 shifts → product=0, done=0, flag=0 next edge; a fresh 6*7 then yields product=42.
- Re-load+enable with A=2, B=3 after 5 shifts of 13*11 → exactly 8 more shifts required; product=6; 143 is never written.

Source files
------------

// File: rtl/shift_add_multiplier_datapath.sv
// Sequential shift-and-add multiplier datapath driven by a Moore controller's strobes.
// One partial-product step per shift cycle; signed mode multiplies magnitudes and fixes the sign at the end.
module shift_add_multiplier_datapath #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  parameter int CNT_W  = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 shift,
  input  logic                 sync_reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 flag,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] count;
  logic             armed;
  logic             neg;

  logic [PW-1:0]    partial;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    result;

  // -2^(WIDTH-1) negates to itself, which read unsigned is exactly its magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if ((SIGNED != 0) && v[WIDTH-1])
      return -v;
    else
      return v;
  endfunction

  function automatic logic apply_sign(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0)
      return a[WIDTH-1] ^ b[WIDTH-1];
    else
      return 1'b0;
  endfunction

  function automatic logic [PW-1:0] sign_correct(input logic [PW-1:0] v, input logic n);
    if (n)
      return -v;
    else
      return v;
  endfunction

  assign flag    = armed && (count == LAST);
  assign partial = mplier[0] ? mcand : '0;
  assign sum     = acc + partial;
  assign result  = sign_correct(sum, neg);

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      count   <= '0;
      armed   <= 1'b0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!sync_reset) begin
        mcand  <= '0;
        mplier <= '0;
        acc    <= '0;
        count  <= '0;
        armed  <= 1'b0;
        neg    <= 1'b0;
      end else if (load && enable) begin
        mcand  <= {{WIDTH{1'b0}}, magnitude(multiplicand)};
        mplier <= magnitude(multiplier);
        acc    <= '0;
        count  <= '0;
        armed  <= 1'b1;
        neg    <= apply_sign(multiplicand, multiplier);
      end else if (shift && armed) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + CNT_W'(1);
        // Final step: publish the corrected sum and disarm until the next load.
        if (flag) begin
          product <= result;
          done    <= 1'b1;
          armed   <= 1'b0;
          count   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_datapath.sv
// Bench for shift_add_multiplier_datapath: an unsigned and a signed instance share stimulus;
// results come from a table of known products and a plain-arithmetic reference model.
module tb_shift_add_multiplier_datapath;

  logic       clk = 1'b0;
  logic       reset, load, shift, sync_reset, enable;
  logic [7:0] multiplicand, multiplier;
  logic       flag_u, done_u, flag_s, done_s;
  logic [15:0] product_u, product_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_add_multiplier_datapath #(.WIDTH(8), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .load(load), .shift(shift), .sync_reset(sync_reset),
    .enable(enable), .multiplicand(multiplicand), .multiplier(multiplier),
    .flag(flag_u), .product(product_u), .done(done_u)
  );

  shift_add_multiplier_datapath #(.WIDTH(8), .SIGNED(1)) s_dut (
    .clk(clk), .reset(reset), .load(load), .shift(shift), .sync_reset(sync_reset),
    .enable(enable), .multiplicand(multiplicand), .multiplier(multiplier),
    .flag(flag_s), .product(product_s), .done(done_s)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    bit          sgn;
    logic [15:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int x, y;
    if (sgn) begin
      x = int'($signed(a));
      y = int'($signed(b));
    end else begin
      x = int'(a);
      y = int'(b);
    end
    return 16'(x * y);
  endfunction

  task automatic do_load(input logic [7:0] a, input logic [7:0] b);
    multiplicand = a;
    multiplier   = b;
    load = 1'b1;
    enable = 1'b1;
    tick();
    load = 1'b0;
    enable = 1'b0;
  endtask

  // Full operation on both instances; flag must rise only in the 8th shift cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] pu, output logic [15:0] ps);
    logic [15:0] hold_u, hold_s;
    hold_u = product_u;
    hold_s = product_s;
    do_load(a, b);
    for (int i = 0; i < 8; i++) begin
      shift = 1'b1;
      chk("flag_u", flag_u, (i == 7));
      chk("flag_s", flag_s, (i == 7));
      tick();
      if (i < 7) begin
        chk("early_done_u", done_u, 1'b0);
        chk("hold_prod_u", product_u, hold_u);
        chk("hold_prod_s", product_s, hold_s);
      end
    end
    shift = 1'b0;
    chk("done_u", done_u, 1'b1);
    chk("done_s", done_s, 1'b1);
    chk("prod_u_model", product_u, ref_mul(a, b, 1'b0));
    chk("prod_s_model", product_s, ref_mul(a, b, 1'b1));
    pu = product_u;
    ps = product_s;
    tick();
    chk("done_u_drop", done_u, 1'b0);
    chk("done_s_drop", done_s, 1'b0);
    chk("prod_u_kept", product_u, pu);
  endtask

  initial begin
    vec_t vecs[6];
    logic [15:0] pu, ps;
    logic [7:0] ra, rb;

    vecs[0] = '{a: 8'd13,  b: 8'd11,  sgn: 1'b0, exp: 16'd143};
    vecs[1] = '{a: 8'd255, b: 8'd255, sgn: 1'b0, exp: 16'hFE01};
    vecs[2] = '{a: 8'd0,   b: 8'd200, sgn: 1'b0, exp: 16'd0};
    vecs[3] = '{a: 8'hFD,  b: 8'd5,   sgn: 1'b1, exp: 16'hFFF1};
    vecs[4] = '{a: 8'h80,  b: 8'h80,  sgn: 1'b1, exp: 16'h4000};
    vecs[5] = '{a: 8'd127, b: 8'h80,  sgn: 1'b1, exp: 16'hC080};

    reset = 1'b1; load = 1'b0; shift = 1'b0; sync_reset = 1'b1; enable = 1'b0;
    multiplicand = '0; multiplier = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_prod_u", product_u, 16'd0);
    chk("rst_prod_s", product_s, 16'd0);
    chk("rst_done_u", done_u, 1'b0);
    chk("rst_flag_u", flag_u, 1'b0);
    chk("rst_flag_s", flag_s, 1'b0);

    // load without enable must not arm
    multiplicand = 8'd9; multiplier = 8'd9; load = 1'b1; enable = 1'b0;
    tick();
    load = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("noen_flag", flag_u, 1'b0);
      tick();
      chk("noen_done", done_u, 1'b0);
    end
    shift = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, pu, ps);
      chk($sformatf("table_%0d", i), vecs[i].sgn ? ps : pu, vecs[i].exp);
    end

    // sync_reset mid-operation, after a completed 13*11
    run_op(8'd13, 8'd11, pu, ps);
    do_load(8'd5, 8'd6);
    shift = 1'b1;
    repeat (3) tick();
    sync_reset = 1'b0;
    tick();
    sync_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("sr_flag", flag_u, 1'b0);
      tick();
      chk("sr_done", done_u, 1'b0);
      chk("sr_prod", product_u, 16'd143);
    end
    shift = 1'b0;

    // reset after 4 of 8 shifts, then a fresh 6*7
    do_load(8'd13, 8'd11);
    shift = 1'b1;
    repeat (4) tick();
    shift = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_prod", product_u, 16'd0);
    chk("mid_rst_done", done_u, 1'b0);
    chk("mid_rst_flag", flag_u, 1'b0);
    run_op(8'd6, 8'd7, pu, ps);
    chk("after_rst_42", pu, 16'd42);

    // restart: reload 2*3 after 5 shifts of 13*11
    do_load(8'd13, 8'd11);
    shift = 1'b1;
    repeat (5) tick();
    shift = 1'b0;
    chk("restart_held", product_u, 16'd42);
    run_op(8'd2, 8'd3, pu, ps);
    chk("restart_6", pu, 16'd6);

    // randomized operands against the reference model
    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_op(ra, rb, pu, ps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
